// File: rtl/mul_seq_16bit.sv
// Sequential unsigned 16x16 -> 32-bit shift-add multiplier retiring one multiplier bit per clock.
// Contains the 16-bit carry-lookahead adder it drives once per iteration.

module CLA_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CarryIn,
  output logic [15:0] Sum,
  output logic        CarryOut
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [3:0]  c4;

  assign g = A & B;
  assign p = A ^ B;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B0 = 4 * gi;
      assign c[B0]   = c4[gi];
      assign c[B0+1] = g[B0] | (p[B0] & c4[gi]);
      assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & c4[gi]);
      assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                     | (p[B0+2] & p[B0+1] & p[B0] & c4[gi]);
      assign gg[gi]  = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                     | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
      assign gp[gi]  = &p[B0+3:B0];
    end
  endgenerate

  // Second-level lookahead, fully expanded from CarryIn so no group carry feeds another.
  assign c4[0] = CarryIn;
  assign c4[1] = gg[0] | (gp[0] & CarryIn);
  assign c4[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & CarryIn);
  assign c4[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & CarryIn);
  assign CarryOut = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                  | (gp[3] & gp[2] & gp[1] & gg[0])
                  | (gp[3] & gp[2] & gp[1] & gp[0] & CarryIn);

  assign Sum = p ^ c;
endmodule

module mul_seq_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] cla_b;
  logic [15:0] cla_sum;
  logic        cla_cout;

  assign cla_b = acc_q[0] ? mcand_q : 16'h0000;

  CLA_16bit u_cla (
    .A        (acc_q[31:16]),
    .B        (cla_b),
    .CarryIn  (1'b0),
    .Sum      (cla_sum),
    .CarryOut (cla_cout)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // Abort leaves acc untouched; product is stale until the next done.
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_d = a;
            acc_d   = {16'h0000, b};
            cnt_d   = 4'd0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          acc_d = {cla_cout, cla_sum, acc_q[15:1]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= 16'h0000;
      acc_q   <= 32'h0000_0000;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;
endmodule
